alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter WIDTH, default 32, datapath width of operands and result.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: req0_valid / req1_valid  input  1 each  requester n presents an operation.
- REQ-005: req0_ready / req1_ready  output  1 each  grant to requester n; transfer when valid&ready.
- REQ-006: req0_op / req1_op  input  3 each  opcode: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul.
- REQ-007: req0_a, req0_b / req1_a, req1_b  input  WIDTH each  signed operands A and B.
- REQ-008: rsp_valid  output  1  response available.
- REQ-009: rsp_ready  input  1  consumer accepts response when rsp_valid&rsp_ready.
- REQ-010: rsp_id  output  1  index of requester that issued the operation.
- REQ-011: rsp_result  output  WIDTH  result; rsp_zero  output  1  result equals 0.
- REQ-012: rsp_err  output  1  opcode was 100 or 101 (unsupported).
- REQ-013: busy  output  1  high in any state other than IDLE.

Function
- REQ-014: FSM states IDLE, EXEC, MUL, RESP; exactly one operation in flight.
- REQ-015: In IDLE, at most one reqN_ready is high, and only to a requester whose valid is high (ready is combinational on valid and pointer).
- REQ-016: Both valid in IDLE -> requester named by round-robin pointer granted; pointer then moves to the other requester.
- REQ-017: One valid -> that requester granted regardless of pointer; pointer moves to the other requester.
- REQ-018: On grant, op, a, b and id are latched; next state EXEC for non-mul opcodes, MUL for 011.
- REQ-019: EXEC lasts one cycle: single ALU pass on latched operands, result registered, -> RESP; rsp_valid high at grant cycle T+2.
- REQ-020: slt result is 1 if a<b signed, else 0; add/sub wrap modulo 2^WIDTH.
- REQ-021: Opcodes 100/101: result 0, rsp_zero 1, rsp_err 1, still via EXEC.
- REQ-022: MUL is WIDTH-cycle shift-add using the ALU add: acc=0; each cycle if multiplier bit0 then acc=acc+multiplicand; multiplicand<<1, multiplier>>1.
- REQ-023: MUL result is low WIDTH bits of a*b (identical for signed and unsigned); rsp_valid high at T+WIDTH+1.
- REQ-024: RESP holds rsp_valid and all rsp_* stable until rsp_valid&rsp_ready, then -> IDLE next cycle; no grant in the handshake cycle.
- REQ-025: reqN_ready is 0 in EXEC, MUL and RESP; requester valids held during that time are not consumed.
- REQ-026: rsp_zero derived from final registered result, for all opcodes including mul.

Reset
- REQ-027: reset overrides everything, including mid-MUL or mid-RESP: state IDLE, pointer=0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_err 0, busy 0, both ready 0 in the reset cycle.
- REQ-028: An in-flight operation aborted by reset produces no response.

Structure
- REQ-029: Opcode constants and FSM state encoding in shared package alu_pkg.
- REQ-030: One ALU sub-module instance (ALU, both widths = WIDTH) is the only adder; used by EXEC and every MUL step.

Verification
- REQ-031: req0 add 7,5 alone, rsp_ready=1 -> rsp at T+2: result 12, id 0, zero 0, err 0.
- REQ-032: both valid after reset, req0 sub 3,3 and req1 or 4,1 -> req0 first (result 0, zero 1), then req1 (result 5, id 1).
- REQ-033: req1 mul -3,7 -> rsp_valid exactly at T+33, result 0xFFFFFFEB, ready 0 on both ports throughout.
- REQ-034: req0 slt -1,1 then slt 1,-1 -> results 1 then 0.
- REQ-035: rsp_ready low 5 cycles in RESP -> outputs stable, no new grant despite req0_valid; grant after handshake+1.
- REQ-036: reset asserted at MUL cycle 10 -> IDLE next cycle, no rsp_valid, pointer 0, op 101 afterwards -> err 1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// alu_arbiter slice.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    function automatic logic op_unsupported(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b101);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: one shared adder serves add, sub and slt; unsupported
// opcodes (and mul, which is sequenced outside) produce zero.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic             sub_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] sum_s;
    logic             lt_s;

    // Adder with optional two's-complement negation of b; slt uses its sign.
    always_comb begin
        sub_s = (op == OP_SUB) || (op == OP_SLT);
        if (sub_s) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        sum_s = a + b_eff_s + {{(WIDTH-1){1'b0}}, sub_s};
        // Differing signs cannot overflow the compare: the negative one is less.
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            lt_s = a[WIDTH-1];
        end else begin
            lt_s = sum_s[WIDTH-1];
        end
    end

    // Result selection by opcode.
    always_comb begin
        case (op)
            OP_ADD, OP_SUB: result = sum_s;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_SLT:         result = {{(WIDTH-1){1'b0}}, lt_s};
            default:        result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single-issue ALU; multiply is a
// WIDTH-cycle shift-add that reuses the ALU adder.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_r, next_s;
    logic             ptr_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             id_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             err_r;
    logic [CW-1:0]    cnt_r;

    logic             grant0_s, grant1_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s;
    logic [2:0]       alu_op_s;
    logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_res_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             last_s;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (alu_op_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .result (alu_res_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Arbitration, next state and grant outputs.
    always_comb begin
        next_s   = state_r;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant0_s = ~ptr_r;
                    grant1_s = ptr_r;
                end else if (req0_valid) begin
                    grant0_s = 1'b1;
                end else if (req1_valid) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                end
                if (grant0_s || grant1_s) begin
                    next_s = (sel_op_s == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_EXEC: next_s = ST_RESP;
            ST_MUL: begin
                if (last_s) begin
                    next_s = ST_RESP;
                end else begin
                    next_s = ST_MUL;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_RESP;
                end
            end
            default: next_s = ST_IDLE;
        endcase
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
            next_s   = ST_IDLE;
        end else begin
            next_s = next_s;
        end
    end

    // Request payload mux and ALU operand steering (MUL borrows the adder).
    always_comb begin
        if (grant1_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
        if (state_r == ST_MUL) begin
            alu_op_s = OP_ADD;
            alu_a_s  = result_r;
            alu_b_s  = mcand_r;
        end else begin
            alu_op_s = op_r;
            alu_a_s  = mcand_r;
            alu_b_s  = mplier_r;
        end
        if (mplier_r[0]) begin
            acc_next_s = alu_res_s;
        end else begin
            acc_next_s = result_r;
        end
        last_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Operand latch, pointer update and result datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r    <= 1'b0;
            op_r     <= 3'b000;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            id_r     <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            err_r    <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant0_s || grant1_s) begin
                        ptr_r    <= grant0_s;
                        op_r     <= sel_op_s;
                        mcand_r  <= sel_a_s;
                        mplier_r <= sel_b_s;
                        id_r     <= grant1_s;
                        result_r <= {WIDTH{1'b0}};
                        zero_r   <= 1'b0;
                        err_r    <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                ST_EXEC: begin
                    result_r <= alu_res_s;
                    zero_r   <= (alu_res_s == {WIDTH{1'b0}});
                    err_r    <= op_unsupported(op_r);
                end
                ST_MUL: begin
                    result_r <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        zero_r <= (acc_next_s == {WIDTH{1'b0}});
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    // Outputs come from registers; reset masks them in the reset cycle itself.
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp_valid  = ~reset & (state_r == ST_RESP);
    assign busy       = ~reset & (state_r != ST_IDLE);
    assign rsp_id     = ~reset & id_r;
    assign rsp_result = reset ? {WIDTH{1'b0}} : result_r;
    assign rsp_zero   = ~reset & zero_r;
    assign rsp_err    = ~reset & err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, checked against an arithmetic reference and a round-robin model.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [WIDTH-1:0] rsp_result;

    int          checks = 0;
    int          errors = 0;
    logic        v [2];
    logic [2:0]  opq [2];
    logic [31:0] aq [2];
    logic [31:0] bq [2];
    int          model_ptr;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    task automatic drive();
        req0_valid = v[0]; req0_op = opq[0]; req0_a = aq[0]; req0_b = bq[0];
        req1_valid = v[1]; req1_op = opq[1]; req1_a = aq[1]; req1_b = bq[1];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  begin p = a * b; return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int expected_id();
        if (v[0] && v[1]) return model_ptr;
        else if (v[0])    return 0;
        else              return 1;
    endfunction

    task automatic set_req(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        v[id] = 1'b1; opq[id] = op; aq[id] = a; bq[id] = b;
        drive();
    endtask

    // Grant, execute, hold the response for 'hold' cycles, then handshake.
    task automatic serve(input int hold, input bit rearm);
        int          id;
        int          lat;
        logic [2:0]  op;
        logic [31:0] er;
        id = expected_id();
        op = opq[id];
        er = model_res(op, aq[id], bq[id]);
        @(negedge clk);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("grant0", req0_ready, id == 0);
        chk("grant1", req1_ready, id == 1);
        @(posedge clk); #1;
        v[id] = 1'b0;
        drive();
        model_ptr = 1 - id;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) begin
                chk("busy_high", busy, 1);
                chk("busy_ready0", req0_ready, 0);
                chk("busy_ready1", req1_ready, 0);
            end
        end while (!rsp_valid && lat < 100);
        if (rearm) begin
            v[id] = 1'b1;
            drive();
            #1;
        end
        chk("latency", lat, (op == 3'b011) ? 33 : 2);
        chk("result", rsp_result, er);
        chk("rsp_id", rsp_id, id);
        chk("zero", rsp_zero, er == 32'd0);
        chk("err", rsp_err, (op == 3'b100) || (op == 3'b101));
        last_res = rsp_result;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, er);
            chk("hold_id", rsp_id, id);
            chk("hold_ready0", req0_ready, 0);
            chk("hold_ready1", req1_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_ready0", req0_ready, 0);
        chk("hs_ready1", req1_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; opq[i] = 3'b000; aq[i] = 32'd0; bq[i] = 32'd0;
        end
        model_ptr = 0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        v[0] = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_err", rsp_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        v[0] = 1'b0;
        drive();

        // Both valid straight after reset: req0 wins, then req1.
        set_req(0, 3'b110, 32'd3, 32'd3);
        set_req(1, 3'b001, 32'd4, 32'd1);
        serve(0, 1'b0);
        chk("sub_zero_res", last_res, 32'd0);
        serve(0, 1'b0);
        chk("or_res", last_res, 32'd5);

        set_req(0, 3'b010, 32'd7, 32'd5);
        serve(0, 1'b0);
        chk("add_res", last_res, 32'd12);

        set_req(1, 3'b011, 32'hFFFF_FFFD, 32'd7);
        serve(0, 1'b0);
        chk("mul_res", last_res, 32'hFFFF_FFEB);

        set_req(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
        serve(0, 1'b0);
        chk("slt_lt", last_res, 32'd1);
        set_req(0, 3'b111, 32'd1, 32'hFFFF_FFFF);
        serve(0, 1'b0);
        chk("slt_ge", last_res, 32'd0);

        // Stalled response with req0 asking again; grant only after handshake.
        set_req(0, 3'b010, 32'h7FFF_FFFF, 32'd1);
        serve(5, 1'b1);
        serve(0, 1'b0);
        chk("wrap_res", last_res, 32'h8000_0000);

        // Abort a multiply by reset at MUL cycle 10.
        set_req(0, 3'b011, 32'd1234, 32'd5678);
        @(negedge clk);
        chk("abort_grant", req0_ready, 1);
        @(posedge clk); #1;
        v[0] = 1'b0;
        drive();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        set_req(1, 3'b010, 32'd1, 32'd1);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_ready1", req1_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        v[1] = 1'b0;
        drive();
        model_ptr = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_busy", busy, 0);
        end
        @(posedge clk); #1;
        set_req(0, 3'b101, 32'd9, 32'd9);
        set_req(1, 3'b100, 32'd3, 32'd2);
        serve(0, 1'b0);
        chk("unsup_res", last_res, 32'd0);
        serve(0, 1'b0);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!v[r] && ($urandom_range(1, 0) == 1)) begin
                    case ($urandom_range(3, 0))
                        0:       set_req(r, 3'(int'($urandom_range(7, 0))), 32'h8000_0000, 32'h7FFF_FFFF);
                        1:       set_req(r, 3'(int'($urandom_range(7, 0))), 32'hFFFF_FFFF, 32'd0);
                        default: set_req(r, 3'(int'($urandom_range(7, 0))), $urandom, $urandom);
                    endcase
                end
            end
            if (!v[0] && !v[1]) begin
                set_req(n % 2, 3'(int'($urandom_range(7, 0))), $urandom, $urandom);
            end
            serve($urandom_range(2, 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
